cpu_inst_queue: RTL and testbench



---
 rtl/cpu_inst_queue.sv | 198 +++++++++++++++++++
 tb/tb_cpu_inst_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_inst_queue.sv
// rtl/cpu_inst_queue.sv - instruction queue with RV32I head decode; optional bypass via CPU_IQ_BYPASS_EN
module cpu_inst_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [31:0]           push_inst,
  input  logic [PC_WIDTH-1:0]   push_pc,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [31:0]           head_inst,
  output logic [PC_WIDTH-1:0]   head_pc,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [9:0]            funct,
  output logic [31:0]           imm,
  output logic                  inst_lui,
  output logic                  inst_auipc,
  output logic                  inst_jal,
  output logic                  inst_jalr,
  output logic                  inst_branch,
  output logic                  inst_load,
  output logic                  inst_store,
  output logic                  inst_arlog_imm,
  output logic                  inst_arlog,
  output logic                  inst_misc_mem,
  output logic                  inst_system,
  output logic                  inst_illegal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARLOG_IMM = 7'b0010011;
  localparam logic [6:0] OP_ARLOG     = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  logic [31:0]         r_mem_inst [DEPTH];
  logic [PC_WIDTH-1:0] r_mem_pc   [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;

  logic                w_empty;
  logic                w_full;
  logic                w_bypass;
  logic                w_pop_fire;
  logic                w_push_fire;
  logic                w_write;
  logic                w_read;
  logic [31:0]         w_hi;
  logic [2:0]          w_f3;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

`ifdef CPU_IQ_BYPASS_EN
  // An empty queue forwards the incoming word straight to the head.
  assign w_bypass = w_empty && push_valid && !rst;
`else
  assign w_bypass = 1'b0;
`endif

  assign push_ready  = !w_full;
  assign pop_valid   = !w_empty || w_bypass;
  assign w_pop_fire  = pop_valid && pop_ready && !flush;
  assign w_push_fire = push_valid && !w_full && !flush;
  // A bypassed word that is consumed in the same cycle never touches storage.
  assign w_write     = w_push_fire && !(w_bypass && pop_ready);
  assign w_read      = w_pop_fire && !w_bypass;

  assign w_hi      = w_bypass ? push_inst : r_mem_inst[r_rptr];
  assign head_inst = w_hi;
  assign head_pc   = w_bypass ? push_pc : r_mem_pc[r_rptr];
  assign count     = r_count;
  assign w_f3      = w_hi[14:12];

  // Entry storage; deliberately not reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem_inst[r_wptr] <= push_inst;
      r_mem_pc[r_wptr]   <= push_pc;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over any handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) r_wptr <= r_wptr + AW'(1);
      if (w_read)  r_rptr <= r_rptr + AW'(1);
      case ({w_write, w_read})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Combinational decode of the head word, all zero while no head is valid.
  always_comb begin
    inst_lui       = 1'b0;
    inst_auipc     = 1'b0;
    inst_jal       = 1'b0;
    inst_jalr      = 1'b0;
    inst_branch    = 1'b0;
    inst_load      = 1'b0;
    inst_store     = 1'b0;
    inst_arlog_imm = 1'b0;
    inst_arlog     = 1'b0;
    inst_misc_mem  = 1'b0;
    inst_system    = 1'b0;
    inst_illegal   = 1'b0;
    rd             = 5'd0;
    rs1            = 5'd0;
    rs2            = 5'd0;
    funct          = 10'd0;
    imm            = 32'd0;
    if (pop_valid) begin
      rd         = w_hi[11:7];
      rs1        = w_hi[19:15];
      rs2        = w_hi[24:20];
      funct[2:0] = w_f3;
      case (w_hi[6:0])
        OP_LUI: begin
          inst_lui = 1'b1;
          imm      = {w_hi[31:12], 12'b0};
        end
        OP_AUIPC: begin
          inst_auipc = 1'b1;
          imm        = {w_hi[31:12], 12'b0};
        end
        OP_JAL: begin
          inst_jal = 1'b1;
          imm      = {{12{w_hi[31]}}, w_hi[19:12], w_hi[20], w_hi[30:21], 1'b0};
        end
        OP_JALR: begin
          inst_jalr = 1'b1;
          imm       = {{20{w_hi[31]}}, w_hi[31:20]};
        end
        OP_BRANCH: begin
          inst_branch = 1'b1;
          imm         = {{20{w_hi[31]}}, w_hi[7], w_hi[30:25], w_hi[11:8], 1'b0};
        end
        OP_LOAD: begin
          inst_load = 1'b1;
          imm       = {{20{w_hi[31]}}, w_hi[31:20]};
        end
        OP_STORE: begin
          inst_store = 1'b1;
          imm        = {{21{w_hi[31]}}, w_hi[30:25], w_hi[11:7]};
        end
        OP_ARLOG_IMM: begin
          inst_arlog_imm = 1'b1;
          imm            = {{20{w_hi[31]}}, w_hi[31:20]};
          // Only the shift-immediate forms carry a meaningful funct7.
          if (w_f3 == 3'b001 || w_f3 == 3'b101) funct[9:3] = w_hi[31:25];
        end
        OP_ARLOG: begin
          inst_arlog = 1'b1;
          funct[9:3] = w_hi[31:25];
        end
        OP_MISC_MEM: begin
          inst_misc_mem = 1'b1;
        end
        OP_SYSTEM: begin
          inst_system = 1'b1;
          imm         = {{20{w_hi[31]}}, w_hi[31:20]};
        end
        default: begin
          inst_illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_inst_queue.sv
// tb/tb_cpu_inst_queue.sv - scoreboard bench for cpu_inst_queue
module tb_cpu_inst_queue;

  localparam int DEPTH = 4;
  localparam int PCW   = 32;

  typedef struct packed {
    logic [31:0]    inst;
    logic [PCW-1:0] pc;
  } ent_t;

  logic clk, rst, flush, push_valid, push_ready, pop_valid, pop_ready;
  logic [31:0] push_inst, head_inst, imm;
  logic [PCW-1:0] push_pc, head_pc;
  logic [4:0] rd, rs1, rs2;
  logic [9:0] funct;
  logic f_lui, f_auipc, f_jal, f_jalr, f_branch, f_load, f_store;
  logic f_arlog_imm, f_arlog, f_misc_mem, f_system, f_illegal;
  logic [$clog2(DEPTH):0] count;
  logic [11:0] flags;

  int total = 0;
  int bad   = 0;

  ent_t exp_q[$];

  logic [6:0] op_tab [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                              7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  cpu_inst_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_inst(push_inst), .push_pc(push_pc),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .head_inst(head_inst), .head_pc(head_pc),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct(funct), .imm(imm),
    .inst_lui(f_lui), .inst_auipc(f_auipc), .inst_jal(f_jal), .inst_jalr(f_jalr),
    .inst_branch(f_branch), .inst_load(f_load), .inst_store(f_store),
    .inst_arlog_imm(f_arlog_imm), .inst_arlog(f_arlog), .inst_misc_mem(f_misc_mem),
    .inst_system(f_system), .inst_illegal(f_illegal),
    .count(count)
  );

  assign flags = {f_lui, f_auipc, f_jal, f_jalr, f_branch, f_load, f_store,
                  f_arlog_imm, f_arlog, f_misc_mem, f_system, f_illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference decode built from the instruction-format rules using plain integer arithmetic.
  function automatic void ref_decode(input logic [31:0] w, output logic [11:0] fl,
                                     output logic [9:0] fn, output logic [31:0] im);
    int cls = 11;
    int v = 0;
    int f3 = int'(w[14:12]);
    for (int k = 0; k < 11; k++) if (w[6:0] == op_tab[k]) cls = k;
    fl = 12'b1 << (11 - cls);
    case (cls)
      0, 1:       v = int'(w & 32'hFFFF_F000);
      2:          v = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      3, 5, 7, 10: v = (w[31] ? -2048 : 0) + int'(w[30:20]);
      4:          v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      6:          v = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]);
      default:    v = 0;
    endcase
    im = 32'(v);
    fn = 10'(f3);
    if (cls == 8 || (cls == 7 && (f3 == 1 || f3 == 5))) fn = fn + 10'(int'(w[31:25]) * 8);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 12);
    if (k < 11) r[6:0] = op_tab[k];
    return r;
  endfunction

  // Reference model advance at the clock edge, mirroring what the design should have accepted.
  task automatic model_update();
    int sz;
    sz = exp_q.size();
    if (rst || flush) begin
      exp_q.delete();
    end else begin
`ifdef CPU_IQ_BYPASS_EN
      if (sz == 0 && push_valid) begin
        if (!pop_ready) exp_q.push_back('{inst: push_inst, pc: push_pc});
      end else begin
`else
      begin
`endif
        if (sz > 0 && pop_ready) void'(exp_q.pop_front());
        if (push_valid && sz < DEPTH) exp_q.push_back('{inst: push_inst, pc: push_pc});
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  int         m_sz;
  logic       m_pv;
  ent_t       m_e;
  logic [11:0] m_fl;
  logic [9:0] m_fn;
  logic [31:0] m_im;

  // Monitor: compare DUT outputs against the head of the scoreboard every cycle.
  always @(negedge clk) begin
    m_sz = exp_q.size();
    m_pv = (m_sz > 0);
`ifdef CPU_IQ_BYPASS_EN
    if (m_sz == 0 && push_valid && !rst) m_pv = 1'b1;
`endif
    chk("count", 32'(count), 32'(m_sz));
    chk("push_ready", 32'(push_ready), 32'(m_sz < DEPTH));
    chk("pop_valid", 32'(pop_valid), 32'(m_pv));
    if (m_pv) begin
      m_e = (m_sz > 0) ? exp_q[0] : '{inst: push_inst, pc: push_pc};
      ref_decode(m_e.inst, m_fl, m_fn, m_im);
      chk("head_inst", head_inst, m_e.inst);
      chk("head_pc", head_pc, m_e.pc);
      chk("rd", 32'(rd), 32'(m_e.inst[11:7]));
      chk("rs1", 32'(rs1), 32'(m_e.inst[19:15]));
      chk("rs2", 32'(rs2), 32'(m_e.inst[24:20]));
      chk("flags", 32'(flags), 32'(m_fl));
      chk("funct", 32'(funct), 32'(m_fn));
      chk("imm", imm, m_im);
    end else begin
      chk("idle_flags", 32'(flags), 32'd0);
      chk("idle_funct", 32'(funct), 32'd0);
      chk("idle_imm", imm, 32'd0);
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_inst = 32'd0; push_pc = '0;

    @(negedge clk);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_push_ready", 32'(push_ready), 32'd1);
    chk("reset_pop_valid", 32'(pop_valid), 32'd0);
    step(); step();
    rst = 1'b0;

    // addi x1, x0, 5 into empty queue
    push_valid = 1'b1; push_inst = 32'h0050_0093; push_pc = 32'h100;
    step();
    push_valid = 1'b0;
    @(negedge clk);
    chk("addi_pop_valid", 32'(pop_valid), 32'd1);
    chk("addi_arlog_imm", 32'(f_arlog_imm), 32'd1);
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_rs1", 32'(rs1), 32'd0);
    chk("addi_imm", imm, 32'h0000_0005);
    chk("addi_funct", 32'(funct), 32'h000);
    chk("addi_pc", head_pc, 32'h100);
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;

    // srai then beq -4
    push_valid = 1'b1; push_inst = 32'h4020_D093; push_pc = 32'h104;
    step();
    push_inst = 32'hFE00_0EE3; push_pc = 32'h108;
    step();
    push_valid = 1'b0;
    @(negedge clk);
    chk("srai_funct", 32'(funct), 32'h105);
    chk("srai_imm", imm, 32'h0000_0402);
    pop_ready = 1'b1;
    step();
    @(negedge clk);
    chk("beq_branch", 32'(f_branch), 32'd1);
    chk("beq_imm", imm, 32'hFFFF_FFFC);
    step();
    pop_ready = 1'b0;

    // illegal opcode, then empty queue
    push_valid = 1'b1; push_inst = 32'h0000_007F; push_pc = 32'h10C;
    step();
    push_valid = 1'b0;
    @(negedge clk);
    chk("illegal_flags", 32'(flags), 32'h001);
    chk("illegal_imm", imm, 32'd0);
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    @(negedge clk);
    chk("empty_flags", 32'(flags), 32'd0);
    chk("empty_imm", imm, 32'd0);
    chk("empty_funct", 32'(funct), 32'd0);
    chk("empty_rd", 32'(rd), 32'd0);

    // fill to DEPTH, then push into full queue with a pop
    push_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push_inst = rand_inst(); push_pc = 32'(32'h200 + i * 4);
      step();
    end
    push_valid = 1'b0;
    @(negedge clk);
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_push_ready", 32'(push_ready), 32'd0);
    push_valid = 1'b1; pop_ready = 1'b1; push_inst = 32'h0000_0013; push_pc = 32'h300;
    step();
    push_valid = 1'b0; pop_ready = 1'b0;
    @(negedge clk);
    chk("full_pop_count", 32'(count), 32'(DEPTH - 1));

    // flush with a concurrent push
    flush = 1'b1; push_valid = 1'b1; push_inst = 32'h0000_0033;
    step();
    flush = 1'b0; push_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_pop_valid", 32'(pop_valid), 32'd0);
    chk("flush_push_ready", 32'(push_ready), 32'd1);

    // reset mid-operation
    push_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_inst = rand_inst(); push_pc = 32'(32'h400 + i * 4);
      step();
    end
    push_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    step();
    @(negedge clk);
    chk("midrst_count", 32'(count), 32'd0);
    rst = 1'b0;
    push_valid = 1'b1; push_inst = 32'h0050_0093; push_pc = 32'h500;
    step();
    push_valid = 1'b0;
    @(negedge clk);
    chk("after_rst_pc", head_pc, 32'h500);
    chk("after_rst_count", 32'(count), 32'd1);
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;

`ifdef CPU_IQ_BYPASS_EN
    push_valid = 1'b1; pop_ready = 1'b1; push_inst = 32'h0050_0093; push_pc = 32'h600;
    #1;
    chk("bypass_pop_valid", 32'(pop_valid), 32'd1);
    chk("bypass_rd", 32'(rd), 32'd1);
    step();
    push_valid = 1'b0; pop_ready = 1'b0;
    @(negedge clk);
    chk("bypass_count", 32'(count), 32'd0);
`endif

    // randomized traffic with alternating fill and drain bias
    for (int c = 0; c < 800; c++) begin
      int bias;
      bias = ((c / 100) % 2 == 0) ? 7 : 3;
      push_valid = ($urandom_range(0, 9) < bias);
      pop_ready  = ($urandom_range(0, 9) >= bias);
      flush      = ($urandom_range(0, 59) == 0);
      push_inst  = rand_inst();
      push_pc    = $urandom & 32'hFFFF_FFFC;
      step();
    end
    push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0;
    step();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
